// File: rtl/pipelined_barrel_shifter_pkg.sv
// shifter_pkg: op encoding and stage-record sizing for the pipelined barrel shifter.
// SHIFTER_FLAGS_EN adds carry/zero bits to every stage record.
package shifter_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_op_e;
`ifdef SHIFTER_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif
  function automatic int stage_w(input int width);
    return 1 + OP_W + $clog2(width) + width + FLAG_W;
  endfunction
  function automatic logic is_right(input logic [OP_W-1:0] op);
    return op == SHIFT_SRL || op == SHIFT_SRA || op == SHIFT_ROR;
  endfunction
endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// shift_stage: one pipeline level applying a conditional 2**STAGE left shift or rotate.
// The last level also undoes the entry bit-reversal of right ops (and forms the zero flag under SHIFTER_FLAGS_EN).
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGE = 0,
  localparam int SHW = $clog2(WIDTH),
  localparam int SW = stage_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [SW-1:0] s_i,
  output logic [SW-1:0] s_o
);
  localparam int S = 1 << STAGE;
  localparam bit LAST = STAGE == SHW - 1;
  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data;
`ifdef SHIFTER_FLAGS_EN
    logic             carry;
    logic             zero;
`endif
  } stage_t;
  stage_t a, s_d, s_q;
  logic [WIDTH-1:0] sh, res, rev;
  logic fill, rot, en;
  assign a = s_i;
  assign s_o = s_q;
  // Right shifts arrive bit-reversed, so the SRA sign bit sits at bit 0 and refills itself.
  always_comb begin
    fill = a.op == SHIFT_SRA && a.data[0];
    rot = a.op == SHIFT_ROL || a.op == SHIFT_ROR;
    en = a.shamt[STAGE] && a.op <= SHIFT_ROR;
    sh = rot ? {a.data[WIDTH-1-S:0], a.data[WIDTH-1-:S]} : {a.data[WIDTH-1-S:0], {S{fill}}};
    res = en ? sh : a.data;
    rev = {<<{res}};
    s_d = a;
    s_d.data = LAST && is_right(a.op) ? rev : res;
`ifdef SHIFTER_FLAGS_EN
    s_d.zero = LAST ? s_d.data == '0 : a.zero;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) s_q <= '0;
    else if (!stall) s_q <= s_d;
  end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SHW-stage shift/rotate pipeline with valid/ready and global stall.
// Define SHIFTER_FLAGS_EN to add registered out_zero/out_carry outputs.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);
  localparam int SW = stage_w(WIDTH);
  logic [SW-1:0] pipe [SHW+1];
  logic [WIDTH-1:0] entry_data, rev_data;
  logic stall;
  assign stall = out_valid && !out_ready;
  assign in_ready = !stall;
  assign rev_data = {<<{in_data}};
  assign entry_data = is_right(in_op) ? rev_data : in_data;
`ifdef SHIFTER_FLAGS_EN
  logic [SHW-1:0] lidx, ridx;
  logic carry_d;
  // WIDTH-shamt wraps to the right index in SHW bits; shamt=0 is masked below.
  assign lidx = SHW'(0) - in_shamt;
  assign ridx = in_shamt - SHW'(1);
  assign carry_d = in_shamt == '0 ? 1'b0 :
                   (in_op == SHIFT_SLL || in_op == SHIFT_ROL) ? in_data[lidx] :
                   is_right(in_op) ? in_data[ridx] : 1'b0;
  assign pipe[0] = {in_valid, in_op, in_shamt, entry_data, carry_d, 1'b0};
  assign out_carry = pipe[SHW][1];
  assign out_zero = pipe[SHW][0];
`else
  assign pipe[0] = {in_valid, in_op, in_shamt, entry_data};
`endif
  assign out_valid = pipe[SHW][SW-1];
  assign out_data = pipe[SHW][FLAG_W +: WIDTH];
  for (genvar i = 0; i < SHW; i++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .STAGE(i)) u_stage (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .s_i(pipe[i]),
      .s_o(pipe[i+1])
    );
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: vector table, stall/reset sequences and random traffic against a reference model.
module tb_pipelined_barrel_shifter;
  localparam int W = 32;
  localparam int SHW = 5;
  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   op;
    int           sh;
    logic [W-1:0] exp;
    logic         zero;
    logic         carry;
    string        name;
  } vec_t;
  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         carry;
  } res_t;
  logic clk = 0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [SHW-1:0] in_shamt;
  logic [2:0] in_op;
`ifdef SHIFTER_FLAGS_EN
  logic out_zero, out_carry;
`endif
  res_t exp_q[$];
  vec_t tv [17];
  int n_chk = 0, n_fail = 0, n_out = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_shamt(in_shamt),
    .in_op(in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef SHIFTER_FLAGS_EN
    ,
    .out_zero(out_zero),
    .out_carry(out_carry)
`endif
  );

  function automatic res_t model(logic [W-1:0] d, logic [2:0] op, int sh);
    logic [2*W-1:0] l, r;
    res_t o;
    l = {{W{1'b0}}, d} << sh;
    r = {d, {W{1'b0}}} >> sh;
    case (op)
      3'd0: o.data = l[W-1:0];
      3'd1: o.data = r[2*W-1:W];
      3'd2: o.data = W'($signed(d) >>> sh);
      3'd3: o.data = l[W-1:0] | l[2*W-1:W];
      3'd4: o.data = r[2*W-1:W] | r[W-1:0];
      default: o.data = d;
    endcase
    o.carry = (sh == 0 || op > 3'd4) ? 1'b0 : (op == 3'd0 || op == 3'd3) ? l[W] : r[W-1];
    o.zero = o.data == '0;
    return o;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic acc, emit;
    res_t e;
    acc = in_valid && in_ready && !reset;
    emit = out_valid && out_ready && !reset;
    if (emit) begin
      n_out++;
      if (exp_q.size() == 0) check("spurious_out", W'(out_valid), '0);
      else begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e.data);
`ifdef SHIFTER_FLAGS_EN
        check("sb_zero", W'(out_zero), W'(e.zero));
        check("sb_carry", W'(out_carry), W'(e.carry));
`endif
      end
    end
    if (acc) exp_q.push_back(model(in_data, in_op, int'(in_shamt)));
    @(posedge clk);
    #1;
    if (reset) exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    in_valid = 1;
    in_data = v.data;
    in_op = v.op;
    in_shamt = SHW'(v.sh);
    out_ready = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({v.name, "_lat"}, W'(lat), W'(SHW));
    check({v.name, "_data"}, out_data, v.exp);
`ifdef SHIFTER_FLAGS_EN
    check({v.name, "_zero"}, W'(out_zero), W'(v.zero));
    check({v.name, "_carry"}, W'(out_carry), W'(v.carry));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", W'(exp_q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    int sent, base;
    tv[0]  = '{32'h000001C1, 3'd0, 3,  32'h00000E08, 1'b0, 1'b0, "sll3"};
    tv[1]  = '{32'h80000010, 3'd2, 4,  32'hF8000001, 1'b0, 1'b0, "sra4"};
    tv[2]  = '{32'h80000010, 3'd1, 4,  32'h08000001, 1'b0, 1'b0, "srl4"};
    tv[3]  = '{32'h00000001, 3'd4, 1,  32'h80000000, 1'b0, 1'b1, "ror1"};
    tv[4]  = '{32'h80000001, 3'd3, 31, 32'hC0000000, 1'b0, 1'b0, "rol31"};
    tv[5]  = '{32'h12345678, 3'd7, 7,  32'h12345678, 1'b0, 1'b0, "rsv7"};
    tv[6]  = '{32'h80000000, 3'd0, 1,  32'h00000000, 1'b1, 1'b1, "sll1_zero"};
    tv[7]  = '{32'h00000003, 3'd1, 1,  32'h00000001, 1'b0, 1'b1, "srl1"};
    tv[8]  = '{32'h80000000, 3'd2, 0,  32'h80000000, 1'b0, 1'b0, "sra0"};
    tv[9]  = '{32'h7FFFFFF0, 3'd2, 31, 32'h00000000, 1'b1, 1'b1, "sra31_pos"};
    tv[10] = '{32'hDEADBEEF, 3'd3, 0,  32'hDEADBEEF, 1'b0, 1'b0, "rol0"};
    tv[11] = '{32'h0000FFFF, 3'd5, 16, 32'h0000FFFF, 1'b0, 1'b0, "rsv5"};
    tv[12] = '{32'h80000000, 3'd2, 31, 32'hFFFFFFFF, 1'b0, 1'b0, "sra31_neg"};
    tv[13] = '{32'h12345678, 3'd4, 16, 32'h56781234, 1'b0, 1'b0, "ror16"};
    tv[14] = '{32'h00000001, 3'd0, 31, 32'h80000000, 1'b0, 1'b0, "sll31"};
    tv[15] = '{32'hFFFFFFFF, 3'd1, 31, 32'h00000001, 1'b0, 1'b1, "srl31"};
    tv[16] = '{32'hF000000F, 3'd3, 4,  32'h000000FF, 1'b0, 1'b1, "rol4"};

    reset = 1;
    in_valid = 0;
    in_data = '0;
    in_op = '0;
    in_shamt = '0;
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data", out_data, '0);
`ifdef SHIFTER_FLAGS_EN
    check("rst_out_zero", W'(out_zero), '0);
    check("rst_out_carry", W'(out_carry), '0);
`endif
    reset = 0;
    #1;
    check("rst_in_ready", W'(in_ready), 32'd1);

    foreach (tv[i]) run_vec(tv[i]);

    // eight back-to-back ops, downstream stalls for three cycles while results stream
    sent = 0;
    base = n_out;
    for (int c = 0; c < 30; c++) begin
      in_valid = sent < 8;
      in_data = $urandom;
      in_op = 3'($urandom_range(0, 7));
      in_shamt = SHW'($urandom);
      out_ready = !(c >= 6 && c <= 8);
      #1;
      check("stall_in_ready", W'(in_ready), (c >= 6 && c <= 8) ? '0 : 32'd1);
      if (c == 6) held = out_data;
      if (c == 7 || c == 8) check("stall_hold", out_data, held);
      if (in_valid && in_ready) sent++;
      tick();
    end
    check("stall_count", W'(n_out - base), 32'd8);
    check("stall_empty", W'(exp_q.size()), '0);

    // random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      in_op = 3'($urandom_range(0, 7));
      in_shamt = SHW'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      tick();
    end
    drain();

    // reset with three ops in flight; input during reset must be ignored
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1;
      in_data = $urandom;
      in_op = 3'($urandom_range(0, 4));
      in_shamt = SHW'($urandom_range(1, 31));
      #1;
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    in_valid = 0;
    #1;
    check("mid_rst_valid", W'(out_valid), '0);
    for (int c = 0; c < 10; c++) begin
      check("mid_rst_stale", W'(out_valid), '0);
      tick();
    end
    run_vec('{32'h000001C1, 3'd0, 3, 32'h00000E08, 1'b0, 1'b0, "post_rst"});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the ALU's 32-bit combinational left barrel shifter.
- Supports WIDTH-bit logical/arithmetic shifts and rotates in both directions.
- One register stage per shift level, with a valid/ready handshake.
- Sits between the register-file read stage and ALU result mux; lets the shifter run at full clock rate without limiting the ALU critical path.

Parameters:
WIDTH, 32, data width in bits; power of 2, 8..64.
SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, must not be overridden.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  input operation valid.
in_ready  output  1  shifter can accept an operation this cycle.
in_data  input  WIDTH  operand.
in_shamt  input  SHW  shift amount, 0..WIDTH-1.
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 reserved.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_data  output  WIDTH  result.

Behaviour:
- Handshake: transfer on valid && ready at a rising edge, on either side.
- Pipeline: SHW stages. Stage k applies a shift of 2^k if shamt bit k is set (LSB stage first).
- Each stage register holds data, op, shamt, valid.
- Latency: exactly SHW cycles from input acceptance to out_valid with no stall; 5 cycles for WIDTH=32.
- Throughput: one operation per cycle.
- Stall is global. stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - During a stall, every stage register holds its value.
- Bubbles are not collapsed. Invalid stages advance when not stalled.
- Ordering: results leave in acceptance order; no drop, no duplication.
- out_data and out_valid are driven directly from the final stage register.
- Fill rules:
  - SLL, SRL: vacated bits filled with 0.
  - SRA: vacated bits filled with operand bit WIDTH-1.
  - ROL, ROR: bits wrap around.
- Reserved op: result equals in_data unchanged, regardless of shamt.
- shamt = 0: result equals in_data for all ops.
- Right ops are implemented by bit-reversing at entry and exit around the left-shifting core, or with direct right muxes; either is acceptable if results match.
- Reset:
  - All stage valid bits are cleared; out_valid = 0 and out_data = 0 the cycle after reset is sampled high.
  - in_ready = 1 whenever reset is low and the pipeline is not stalled.
  - Reset mid-operation discards all in-flight operations; none appear at the output afterwards.
  - in_valid is ignored while reset is high.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.

Optional Feature:
SHIFTER_FLAGS_EN
- Defined: adds outputs out_zero (1 bit) and out_carry (1 bit), registered alongside out_data and held during stalls.
  - out_zero = (out_data == 0).
  - out_carry = last bit shifted or rotated out:
    - SLL/ROL: in_data[WIDTH-shamt].
    - SRL/SRA/ROR: in_data[shamt-1].
    - 0 when shamt = 0 or the op is reserved.
  - Carry is computed at acceptance and pipelined with the data.
  - Both flags reset to 0.
- Undefined: the ports and their logic are absent.

Decomposition:
- shifter_pkg:
  - shift_op_e enum (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL, SHIFT_ROR).
  - OP_W = 3 constant.
  - stage_t struct-building function taking WIDTH.
- Sub-module shift_stage:
  - One level: parameter STAGE index; conditional 2^STAGE shift mux plus its pipeline register with stall hold and synchronous reset.
  - Instantiated SHW times in a generate loop.

Test Plan:
1. WIDTH=32, SLL in_data=0x000001C1, shamt=3 -> out_data=0x00000E08, out_valid exactly 5 cycles after acceptance.
2. SRA in_data=0x80000010, shamt=4 -> 0xF8000001; SRL, same operands -> 0x08000001.
3. ROR in_data=0x00000001, shamt=1 -> 0x80000000; ROL in_data=0x80000001, shamt=31 -> 0xC0000000; op=111, shamt=7 -> unchanged.
4. Eight back-to-back ops with out_ready low for 3 cycles mid-stream -> in_ready low exactly during those cycles, all 8 results in order, none lost or repeated, out_data stable while stalled.
5. Three ops in flight, reset high 1 cycle -> out_valid=0 next cycle, no stale result appears, a new op then completes with latency 5.
6. With SHIFTER_FLAGS_EN defined: SLL in_data=0x80000000, shamt=1 -> out_data=0, out_zero=1, out_carry=1.
   SRL in_data=0x00000003, shamt=1 -> out_data=0x00000001, out_zero=0, out_carry=1.
